// File: rtl/sc_pe_pkg.sv
// Shared encodings, config-field layout and LFSR tap table for the stochastic-computing PE.
package sc_pe_pkg;

  typedef enum logic [1:0] {
    MODE_AND  = 2'b00,
    MODE_XNOR = 2'b01,
    MODE_MUX  = 2'b10,
    MODE_BYP  = 2'b11
  } sc_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } sc_state_e;

  localparam int CFG_MODE_LSB = 0;
  localparam int CFG_ACC_BIT  = 2;

  function automatic int cfg_w(input int dw);
    return 3 + 3 * dw;
  endfunction

  // idx 0/1/2 selects seed_a/seed_b/seed_c
  function automatic int cfg_seed_lsb(input int dw, input int idx);
    return 3 + idx * dw;
  endfunction

  // Maximal-length Fibonacci taps; bit n-1 set for tap position n.
  function automatic logic [15:0] lfsr_taps(input int dw);
    case (dw)
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h00B8;
    endcase
  endfunction

endpackage

// File: rtl/sc_lfsr_sng.sv
// LFSR-based stochastic number generator: emits (lfsr <= operand) and steps on en.
module sc_lfsr_sng
  import sc_pe_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          en,
  input  logic [DW-1:0] seed,
  input  logic [DW-1:0] operand,
  output logic          sbit
);

  localparam logic [15:0]   TAPS_ALL = lfsr_taps(DW);
  localparam logic [DW-1:0] TAPS     = TAPS_ALL[DW-1:0];
  localparam logic [DW-1:0] ONE      = {{(DW-1){1'b0}}, 1'b1};

  logic [DW-1:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     lfsr <= '0;
    else if (load)  lfsr <= (seed == '0) ? ONE : seed;  // all-zero state would lock up
    else if (en)    lfsr <= {lfsr[DW-2:0], ^(lfsr & TAPS)};
  end

  assign sbit = (lfsr <= operand);

endmodule

// File: rtl/sc_pe_stream.sv
// Sequential SC processing element: SNG streams -> SC op -> ones count, with saturating accumulate.
module sc_pe_stream
  import sc_pe_pkg::*;
#(
  parameter  int DW    = 8,
  localparam int P     = 2**DW - 1,
  localparam int CFG_W = 3 + 3*DW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DW-1:0]    x1,
  input  logic [DW-1:0]    x2,
  input  logic [DW-1:0]    x_mem,
  input  logic [CFG_W-1:0] config_sig,
  output logic             busy,
  output logic             done,
  output logic [DW-1:0]    y_next,
  output logic [DW-1:0]    y_outmem
);

  localparam logic [DW-1:0] P_V      = '1;
  localparam logic [DW-1:0] LAST     = P_V - 1'b1;
  localparam logic [DW-1:0] HALF_M1  = {1'b0, {(DW-1){1'b1}}};
  localparam int            SEED_LSB = cfg_seed_lsb(DW, 0);

  sc_state_e       state;
  logic [DW-1:0]   x1_q, x2_q, xm_q;
  logic [CFG_W-1:0] cfg_q;
  logic [DW-1:0]   cnt, run_cnt;

  sc_mode_e        mode;
  logic            acc_en;
  logic            res_bit, sel;
  logic [DW-1:0]   cnt_nxt, acc_sat;
  logic [DW:0]     acc_sum;

  logic [2:0][DW-1:0] sng_seed, sng_opnd;
  logic [2:0]         sng_bit;

  assign mode   = sc_mode_e'(cfg_q[CFG_MODE_LSB +: 2]);
  assign acc_en = cfg_q[CFG_ACC_BIT];

  // C compares against 2^(DW-1)-1, so its bit is ~lfsr_c[DW-1]; invert to get the MSB select.
  assign sng_opnd[0] = x1_q;
  assign sng_opnd[1] = x2_q;
  assign sng_opnd[2] = HALF_M1;
  assign sel         = ~sng_bit[2];

  for (genvar i = 0; i < 3; i++) begin : g_sng
    assign sng_seed[i] = cfg_q[SEED_LSB + i*DW +: DW];
    sc_lfsr_sng #(.DW(DW)) u_sng (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (state == ST_LOAD),
      .en      (state == ST_RUN),
      .seed    (sng_seed[i]),
      .operand (sng_opnd[i]),
      .sbit    (sng_bit[i])
    );
  end

  always_comb begin
    res_bit = 1'b0;
    case (mode)
      MODE_AND:  res_bit = sng_bit[0] & sng_bit[1];
      MODE_XNOR: res_bit = ~(sng_bit[0] ^ sng_bit[1]);
      MODE_MUX:  res_bit = sel ? sng_bit[1] : sng_bit[0];
      MODE_BYP:  res_bit = sng_bit[0];
      default:   res_bit = 1'b0;
    endcase
    cnt_nxt = cnt + {{(DW-1){1'b0}}, res_bit};
    acc_sum = {1'b0, cnt_nxt} + {1'b0, xm_q};
    acc_sat = (acc_sum > {1'b0, P_V}) ? P_V : acc_sum[DW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      x1_q     <= '0;
      x2_q     <= '0;
      xm_q     <= '0;
      cfg_q    <= '0;
      cnt      <= '0;
      run_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      y_next   <= '0;
      y_outmem <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          x1_q  <= x1;
          x2_q  <= x2;
          xm_q  <= x_mem;
          cfg_q <= config_sig;
          busy  <= 1'b1;
          state <= ST_LOAD;
        end
        ST_LOAD: begin
          cnt     <= '0;
          run_cnt <= '0;
          state   <= ST_RUN;
        end
        ST_RUN: begin
          cnt     <= cnt_nxt;
          run_cnt <= run_cnt + 1'b1;
          // last stream bit is folded into the outputs on the same edge
          if (run_cnt == LAST) begin
            state    <= ST_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            y_next   <= cnt_nxt;
            y_outmem <= acc_en ? acc_sat : xm_q;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_pe_stream.sv
// Directed bench for sc_pe_stream (DW=8): exact-by-construction SC results, latency, control, reset.
module tb_sc_pe_stream;

  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [DW-1:0]   x1 = '0, x2 = '0, x_mem = '0;
  logic [3+3*DW-1:0] config_sig = '0;
  logic            busy, done;
  logic [DW-1:0]   y_next, y_outmem;

  int checks = 0;
  int failures = 0;

  sc_pe_stream #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x1(x1), .x2(x2), .x_mem(x_mem),
    .config_sig(config_sig), .busy(busy), .done(done), .y_next(y_next), .y_outmem(y_outmem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Launch one operation; inputs are scrambled after the start edge to prove they were latched.
  task automatic run_chk(input string tag, input logic [1:0] mode, input logic acc,
                         input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                         input logic [7:0] sa, input logic [7:0] sb, input logic [7:0] sc,
                         input bit mid_start, input int exp_yn, input int exp_ym);
    int cyc, bcyc, ndone;
    @(negedge clk);
    x1 = a; x2 = b; x_mem = m;
    config_sig = {sc, sb, sa, acc, mode};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x1 = 8'($urandom); x2 = 8'($urandom); x_mem = 8'($urandom);
    config_sig = 27'($urandom);
    cyc = 1; bcyc = 0;
    while (!done && cyc < 400) begin
      if (busy) bcyc++;
      if (mid_start) start = (cyc == 50);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!done) begin
      chk({tag, "_timeout"}, 0, 1);
      return;
    end
    chk({tag, "_done_cycle"}, cyc, 257);
    chk({tag, "_busy_cycles"}, bcyc, 256);
    chk({tag, "_y_next"}, y_next, exp_yn);
    chk({tag, "_y_outmem"}, y_outmem, exp_ym);
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk({tag, "_extra_done"}, ndone, 0);
    chk({tag, "_hold"}, {y_next, y_outmem}, {8'(exp_yn), 8'(exp_ym)});
  endtask

  initial begin
    int nd;
    #23 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_y_next", y_next, 0);
    chk("rst_y_outmem", y_outmem, 0);

    //      tag           mode  acc  x1   x2   xmem sa     sb     sc     mid  yn   ym
    run_chk("byp100",     2'b11, 0, 100,   0,   0, 8'h5A, 8'h33, 8'h71, 0, 100,   0);
    run_chk("and77_255",  2'b00, 0,  77, 255,  12, 8'h5A, 8'h33, 8'h71, 0,  77,  12);
    run_chk("and77_0",    2'b00, 0,  77,   0,   0, 8'h11, 8'h22, 8'h33, 0,   0,   0);
    run_chk("and255_200", 2'b00, 0, 255, 200,   0, 8'h81, 8'h42, 8'h24, 0, 200,   0);
    run_chk("xnor_pp",    2'b01, 0, 255, 255,   0, 8'h5A, 8'h33, 8'h71, 0, 255,   0);
    run_chk("xnor_p0",    2'b01, 0, 255,   0,   0, 8'h5A, 8'h33, 8'h71, 0,   0,   0);
    run_chk("xnor_00",    2'b01, 0,   0,   0,   0, 8'h5A, 8'h33, 8'h71, 0, 255,   0);
    run_chk("acc_sat",    2'b11, 1, 200,   0, 100, 8'h5A, 8'h33, 8'h71, 0, 200, 255);
    run_chk("acc_250",    2'b11, 1, 200,   0,  50, 8'h5A, 8'h33, 8'h71, 0, 200, 250);
    run_chk("acc_off",    2'b11, 0, 200,   0,  33, 8'h5A, 8'h33, 8'h71, 0, 200,  33);
    run_chk("mid_start",  2'b11, 0,  42,   0,   7, 8'h5A, 8'h33, 8'h71, 1,  42,   7);
    run_chk("seed0",      2'b11, 0,   9,   0,   0, 8'h00, 8'h00, 8'h00, 0,   9,   0);
    run_chk("mux_pp",     2'b10, 0, 255, 255,   0, 8'h5A, 8'h33, 8'h71, 0, 255,   0);
    // select = lfsr_c MSB: 127 of 1..255 have MSB 0 (pick A), 128 have MSB 1 (pick B)
    run_chk("mux_a",      2'b10, 0, 255,   0,   0, 8'h5A, 8'h33, 8'h71, 0, 127,   0);
    run_chk("mux_b",      2'b10, 0,   0, 255,   0, 8'h5A, 8'h33, 8'h71, 0, 128,   0);
    run_chk("pre_rst",    2'b11, 1,  60,   0,  40, 8'h5A, 8'h33, 8'h71, 0,  60, 100);

    // abort at RUN cycle 100: reset asserted between edges
    @(negedge clk);
    x1 = 123; x2 = 255; x_mem = 10;
    config_sig = {8'h71, 8'h33, 8'h5A, 1'b1, 2'b00};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_y_next", y_next, 0);
    chk("abort_y_outmem", y_outmem, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (300) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("abort_no_done", nd, 0);
    run_chk("post_rst",   2'b00, 1, 123, 255,  10, 8'h5A, 8'h33, 8'h71, 0, 123, 133);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
